counter_bank_n: RTL



---
 rtl/counter_bank_n.sv | 118 +++++++++++
 1 files changed

// File: rtl/counter_bank_n.sv
// Bank of NUM_CH tick-driven down-counters (one-shot, rate, square wave) with
// per-channel load/control registers and a registered readback of one channel.
module counter_bank_n #(
   parameter int NUM_CH = 3,
   parameter int WIDTH  = 32,
   parameter int CH_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] tick,
   input  logic              counter_we,
   input  logic              counter_reg,
   input  logic [CH_W-1:0]   counter_ch,
   input  logic [WIDTH-1:0]  counter_val,
   input  logic [CH_W-1:0]   rd_ch,
   output logic [WIDTH-1:0]  counter_out,
   output logic [NUM_CH-1:0] counter_OUT,
   output logic [NUM_CH-1:0] terminal
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0]  count  [NUM_CH];
   logic [WIDTH-1:0]  reload [NUM_CH];
   logic [1:0]        mode   [NUM_CH];
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] tick_q;
   logic [NUM_CH-1:0] ev;
   logic [NUM_CH-1:0] wr_hit;
   logic [WIDTH-1:0]  rd_mux;

   // Rate and square modes idle high; one-shot (and its alias 3) idles low.
   function automatic logic init_level(input logic [1:0] m);
      return (m == 2'd1) || (m == 2'd2);
   endfunction

   assign ev = tick & ~tick_q;

   // Out-of-range channel numbers match no channel, so such writes and reads fall through.
   always_comb begin
      wr_hit = '0;
      rd_mux = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (counter_we && (counter_ch == CH_W'(i))) wr_hit[i] = 1'b1;
         if (rd_ch == CH_W'(i)) rd_mux = count[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q      <= '0;
         en          <= '0;
         counter_OUT <= '0;
         terminal    <= '0;
         counter_out <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            count[i]  <= '0;
            reload[i] <= '0;
            mode[i]   <= 2'd0;
         end
      end else begin
         tick_q      <= tick;
         counter_out <= rd_mux;
         terminal    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_hit[i]) begin
               if (counter_reg) begin
                  en[i]          <= counter_val[0];
                  mode[i]        <= counter_val[2:1];
                  counter_OUT[i] <= init_level(counter_val[2:1]);
               end else begin
                  reload[i]      <= counter_val;
                  count[i]       <= counter_val;
                  counter_OUT[i] <= init_level(mode[i]);
               end
            end else begin
               // The rate-mode low pulse lasts one clock; an event cannot recur on the next clock.
               if ((mode[i] == 2'd1) && !counter_OUT[i]) counter_OUT[i] <= 1'b1;
               if (en[i] && ev[i]) begin
                  case (mode[i])
                     2'd1: begin
                        if (count[i] > ONE) begin
                           count[i] <= count[i] - ONE;
                        end else begin
                           count[i]       <= reload[i];
                           counter_OUT[i] <= 1'b0;
                           terminal[i]    <= 1'b1;
                        end
                     end
                     2'd2: begin
                        if (count[i] > ONE) begin
                           count[i] <= count[i] - ONE;
                        end else begin
                           count[i]       <= reload[i];
                           counter_OUT[i] <= ~counter_OUT[i];
                           terminal[i]    <= 1'b1;
                        end
                     end
                     default: begin
                        if (count[i] > ONE) begin
                           count[i] <= count[i] - ONE;
                        end else if (count[i] == ONE) begin
                           count[i]       <= '0;
                           counter_OUT[i] <= 1'b1;
                           terminal[i]    <= 1'b1;
                        end else if (!counter_OUT[i]) begin
                           counter_OUT[i] <= 1'b1;
                           terminal[i]    <= 1'b1;
                        end
                     end
                  endcase
               end
            end
         end
      end
   end

endmodule
